// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback defaults and the pending-queue entry type
package wb_pkg;
  localparam logic [4:0] WB_STATUS_REG = 5'd30;
  localparam logic [31:0] WB_DIV_ERR_CODE = 32'd5;
  typedef struct packed {
    logic live;
    logic [4:0] rd;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: MDU completion handshake (done/reg/data/err from the MDU, ready back from the arbiter)
interface writeback_arbiter_if;
  logic mdu_done;
  logic [4:0] mdu_reg;
  logic [31:0] mdu_data;
  logic mdu_err;
  logic mdu_ready;
  modport master (output mdu_done, mdu_reg, mdu_data, mdu_err, input mdu_ready);
  modport slave (input mdu_done, mdu_reg, mdu_data, mdu_err, output mdu_ready);
endinterface

// File: rtl/wb_pending_fifo.sv
// wb_pending_fifo: circular queue of MDU results with kill-by-register, head pop, two-port youngest-match bypass and full/empty flags
module wb_pending_fifo import wb_pkg::*; #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  wb_entry_t push_entry,
  input  logic pop,
  input  logic kill,
  input  logic [4:0] kill_reg,
  input  logic [4:0] byp_a_reg,
  input  logic [4:0] byp_b_reg,
  output wb_entry_t head,
  output logic empty,
  output logic full,
  output logic byp_a_hit,
  output logic [31:0] byp_a_data,
  output logic byp_b_hit,
  output logic [31:0] byp_b_data
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] wr_ptr, rd_ptr, idx;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      vld <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  // push follows kill so an entry written this cycle is never killed by a same-cycle pipe write
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++)
      if (kill && mem[i].rd == kill_reg) mem[i].live <= 1'b0;
    if (push) mem[wr_ptr] <= push_entry;
  end
  assign head = mem[rd_ptr];
  assign empty = ~|vld;
  assign full = &vld;
  // walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    byp_a_hit = 1'b0;
    byp_a_data = '0;
    byp_b_hit = 1'b0;
    byp_b_data = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + k[AW-1:0];
      if (vld[idx] && mem[idx].live && byp_a_reg != '0 && mem[idx].rd == byp_a_reg) begin
        byp_a_hit = 1'b1;
        byp_a_data = mem[idx].data;
      end
      if (vld[idx] && mem[idx].live && byp_b_reg != '0 && mem[idx].rd == byp_b_reg) begin
        byp_b_hit = 1'b1;
        byp_b_data = mem[idx].data;
      end
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the regfile write port (rf_*) between W-stage pipe writes and queued MDU results (mdu if), tracks busy MDU destinations (busy_mask), forwards queued data to decode (byp_*) and requests a front-end stall (stall_req)
module writeback_arbiter import wb_pkg::*; #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [4:0] STATUS_REG = WB_STATUS_REG,
  parameter logic [31:0] DIV_ERR_CODE = WB_DIV_ERR_CODE
) (
  input  logic clock,
  input  logic reset,
  input  logic pipe_we,
  input  logic [4:0] pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic mdu_issue,
  input  logic [4:0] mdu_issue_reg,
  writeback_arbiter_if.slave mdu,
  output logic rf_we,
  output logic [4:0] rf_reg,
  output logic [31:0] rf_data,
  output logic [31:0] busy_mask,
  input  logic [4:0] byp_a_reg,
  input  logic [4:0] byp_b_reg,
  output logic byp_a_hit,
  output logic [31:0] byp_a_data,
  output logic byp_b_hit,
  output logic [31:0] byp_b_data,
  output logic stall_req
);
  localparam int GW = $clog2(STARVE_LIMIT + 1);
  localparam logic [GW-1:0] LIM = GW'(STARVE_LIMIT);
  wb_entry_t head, push_entry;
  logic empty, full, pipe_wr, accept, pop, head_write;
  logic [GW-1:0] age;
  logic [31:0] busy_next;
  assign pipe_wr = pipe_we && pipe_reg != '0;
  assign mdu.mdu_ready = reset && !full;
  assign accept = mdu.mdu_done && mdu.mdu_ready;
  assign push_entry = mdu.mdu_err ? wb_entry_t'{1'b1, STATUS_REG, DIV_ERR_CODE}
                                  : wb_entry_t'{mdu.mdu_reg != '0, mdu.mdu_reg, mdu.mdu_data};
  // a live head yields to the pipe; a dead head drains unconditionally
  assign pop = !empty && !(head.live && pipe_wr);
  assign head_write = pop && head.live && head.rd != '0;
  assign rf_we = reset && (pipe_wr || head_write);
  assign rf_reg = !rf_we ? '0 : pipe_wr ? pipe_reg : head.rd;
  assign rf_data = !rf_we ? '0 : pipe_wr ? pipe_data : head.data;
  assign stall_req = reset && (full || age == LIM);
  always_comb begin
    busy_next = busy_mask;
    if (accept) busy_next[mdu.mdu_reg] = 1'b0;
    if (mdu_issue && mdu_issue_reg != '0) busy_next[mdu_issue_reg] = 1'b1;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      busy_mask <= '0;
      age <= '0;
    end else begin
      busy_mask <= busy_next;
      age <= (empty || pop) ? '0 : (head.live && age != LIM) ? age + 1'b1 : age;
    end
  wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(accept),
    .push_entry(push_entry),
    .pop(pop),
    .kill(pipe_wr),
    .kill_reg(pipe_reg),
    .byp_a_reg(byp_a_reg),
    .byp_b_reg(byp_b_reg),
    .head(head),
    .empty(empty),
    .full(full),
    .byp_a_hit(byp_a_hit),
    .byp_a_data(byp_a_data),
    .byp_b_hit(byp_b_hit),
    .byp_b_data(byp_b_data)
  );
endmodule
